// File: rtl/phase_meas_ctrl.sv
// Phase-measurement sequencer: discards one capture, averages AVG_N captures,
// then converts high_sum/all_sum to phase in 0.1-degree units with a restoring divider.
module phase_meas_ctrl #(
  parameter int  AVG_N       = 8,
  parameter int  TIMEOUT_CYC = 1000000,
  localparam int SUM_W       = 16 + $clog2(AVG_N)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             phase_end_flag,
  input  logic [15:0]      high_times,
  input  logic [15:0]      all_times,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [11:0]      phase_x10,
  output logic [SUM_W-1:0] high_sum,
  output logic [SUM_W-1:0] all_sum
);

  localparam int DW    = SUM_W + 12;
  localparam int CNT_W = $clog2(AVG_N) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int DC_W  = $clog2(DW + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic [11:0]       phase_q, phase_d;
  logic [SUM_W-1:0]  hsum_q, hsum_d;
  logic [SUM_W-1:0]  asum_q, asum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [SUM_W-1:0]  rem_q, rem_d;

  logic [SUM_W:0]    rem_sh_s;
  logic [SUM_W:0]    rem_sub_s;
  logic [SUM_W:0]    rem_nx_s;
  logic              ge_s;
  logic [DW-1:0]     q_next_s;
  logic [11:0]       result_s;
  logic              to_expire_s;

  // One restoring-division step plus the clamped result of the final step
  always_comb begin
    rem_sh_s  = {rem_q, quo_q[DW-1]};
    rem_sub_s = rem_sh_s - {1'b0, asum_q};
    ge_s      = (rem_sh_s >= {1'b0, asum_q});
    rem_nx_s  = ge_s ? rem_sub_s : rem_sh_s;
    q_next_s  = {quo_q[DW-2:0], ge_s};
    // A zero divisor would yield all-ones; report 0 instead of clamping to full scale
    if (asum_q == {SUM_W{1'b0}}) begin
      result_s = 12'd0;
    end else if (q_next_s > DW'(12'd3600)) begin
      result_s = 12'd3600;
    end else begin
      result_s = 12'(q_next_s);
    end
    to_expire_s = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    terr_d    = terr_q;
    phase_d   = phase_q;
    hsum_d    = hsum_q;
    asum_d    = asum_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    div_cnt_d = '0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          terr_d   = 1'b0;
          hsum_d   = '0;
          asum_d   = '0;
          cnt_d    = '0;
          to_cnt_d = '0;
          state_d  = ST_SYNC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (phase_end_flag) begin
          to_cnt_d = '0;
          state_d  = ST_ACCUM;
        end else if (to_expire_s) begin
          terr_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ACCUM: begin
        // A flag in the expiry cycle takes priority over the timeout
        if (phase_end_flag) begin
          hsum_d   = hsum_q + SUM_W'(high_times);
          asum_d   = asum_q + SUM_W'(all_times);
          cnt_d    = cnt_q + CNT_W'(1);
          to_cnt_d = '0;
          if (cnt_q == CNT_W'(AVG_N - 1)) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_ACCUM;
          end
        end else if (to_expire_s) begin
          terr_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_DIV: begin
        div_cnt_d = div_cnt_q + DC_W'(1);
        // First DIV cycle loads the dividend once the final sums are registered
        if (div_cnt_q == {DC_W{1'b0}}) begin
          quo_d = DW'(hsum_q) * DW'(12'd3600);
          rem_d = '0;
        end else begin
          quo_d = q_next_s;
          rem_d = SUM_W'(rem_nx_s);
          if (div_cnt_q == DC_W'(DW)) begin
            phase_d = result_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      phase_q   <= 12'd0;
      hsum_q    <= '0;
      asum_q    <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      div_cnt_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      phase_q   <= phase_d;
      hsum_q    <= hsum_d;
      asum_q    <= asum_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      div_cnt_q <= div_cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign phase_x10   = phase_q;
  assign high_sum    = hsum_q;
  assign all_sum     = asum_q;

endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Directed bench for phase_meas_ctrl with AVG_N=8 and a shortened timeout.
module tb_phase_meas_ctrl;

  localparam int AVG_N = 8;
  localparam int TO    = 40;
  localparam int SUM_W = 19;
  localparam int LAT   = 32;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             phase_end_flag = 1'b0;
  logic [15:0]      high_times = 16'd0;
  logic [15:0]      all_times = 16'd0;
  logic             busy, done, timeout_err;
  logic [11:0]      phase_x10;
  logic [SUM_W-1:0] high_sum, all_sum;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int lat;
  int d0;

  phase_meas_ctrl #(.AVG_N(AVG_N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
    .phase_end_flag(phase_end_flag), .high_times(high_times), .all_times(all_times),
    .busy(busy), .done(done), .timeout_err(timeout_err), .phase_x10(phase_x10),
    .high_sum(high_sum), .all_sum(all_sum)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic flag(input logic [15:0] h, input logic [15:0] a);
    phase_end_flag = 1'b1;
    high_times = h;
    all_times = a;
    tick();
    phase_end_flag = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int l);
    l = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic run_meas(input logic [15:0] h, input logic [15:0] a, output int l);
    start = 1'b1;
    tick();
    start = 1'b0;
    flag(16'd5, 16'd7);
    for (int i = 0; i < AVG_N; i++) flag(h, a);
    wait_done(100, l);
  endtask

  initial begin
    // reset values
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_phase", phase_x10, 0);
    chk("rst_hsum", high_sum, 0);
    chk("rst_asum", all_sum, 0);
    rst_n = 1'b1;
    tick();

    // T1: basic measurement
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_start", busy, 1);
    flag(16'd5, 16'd7);
    chk("t1_discard", high_sum, 0);
    for (int i = 0; i < AVG_N; i++) flag(16'd100, 16'd400);
    chk("t1_busy_div", busy, 1);
    wait_done(100, lat);
    chk("t1_latency", lat, LAT);
    chk("t1_phase", phase_x10, 900);
    chk("t1_hsum", high_sum, 800);
    chk("t1_asum", all_sum, 3200);
    chk("t1_terr", timeout_err, 0);
    tick();
    chk("t1_done_drop", done, 0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_one_pulse", done_seen - d0, 1);

    // T4: start+flag in IDLE, starts while busy ignored
    start = 1'b1;
    phase_end_flag = 1'b1;
    high_times = 16'd9;
    all_times = 16'd9;
    tick();
    start = 1'b0;
    phase_end_flag = 1'b0;
    chk("t4_busy", busy, 1);
    chk("t4_flag_in_idle", high_sum, 0);
    flag(16'd5, 16'd7);
    chk("t4_discard", high_sum, 0);
    for (int i = 0; i < AVG_N; i++) begin
      if (i == 3) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      start = (i == 5);
      flag(16'd100, 16'd400);
      start = 1'b0;
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, lat);
    chk("t4_done_seen", (lat > 0), 1);
    chk("t4_phase", phase_x10, 900);
    chk("t4_hsum", high_sum, 800);
    chk("t4_asum", all_sum, 3200);
    tick();
    chk("t4_idle", busy, 0);

    // T3: timeout, then flags exactly at the expiry cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(TO + 10, lat);
    chk("t3_to_latency", lat, TO);
    chk("t3_terr", timeout_err, 1);
    chk("t3_phase_kept", phase_x10, 900);
    chk("t3_hsum", high_sum, 0);
    tick();
    chk("t3_busy_drop", busy, 0);
    chk("t3_terr_hold", timeout_err, 1);
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_terr_clear", timeout_err, 0);
    repeat (TO - 1) tick();
    flag(16'd5, 16'd7);
    chk("t3_sync_edge_busy", busy, 1);
    chk("t3_sync_edge_terr", timeout_err, 0);
    repeat (TO - 1) tick();
    flag(16'd100, 16'd400);
    chk("t3_accum_edge_hsum", high_sum, 100);
    chk("t3_accum_edge_busy", busy, 1);
    for (int i = 1; i < AVG_N; i++) flag(16'd100, 16'd400);
    wait_done(100, lat);
    chk("t3_latency", lat, LAT);
    chk("t3_phase", phase_x10, 900);
    chk("t3_terr_final", timeout_err, 0);
    tick();
    chk("t3_one_pulse", done_seen - d0, 1);

    // T2: full-scale and truncation
    run_meas(16'hFFFF, 16'hFFFF, lat);
    chk("t2_latency", lat, LAT);
    chk("t2_hsum", high_sum, 524280);
    chk("t2_asum", all_sum, 524280);
    chk("t2_phase", phase_x10, 3600);
    tick();
    run_meas(16'd1, 16'd7, lat);
    chk("t2b_hsum", high_sum, 8);
    chk("t2b_asum", all_sum, 56);
    chk("t2b_phase", phase_x10, 514);

    // T6: back-to-back start in the cycle after done
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_accepted", busy, 1);
    flag(16'd5, 16'd7);
    for (int i = 0; i < AVG_N; i++) flag(16'd200, 16'd400);
    wait_done(100, lat);
    chk("t6_latency", lat, LAT);
    chk("t6_phase", phase_x10, 1800);
    chk("t6_hsum", high_sum, 1600);
    tick();

    // T5: reset during DIV
    start = 1'b1;
    tick();
    start = 1'b0;
    flag(16'd5, 16'd7);
    for (int i = 0; i < AVG_N; i++) flag(16'd100, 16'd400);
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_phase", phase_x10, 0);
    chk("t5_hsum", high_sum, 0);
    chk("t5_asum", all_sum, 0);
    d0 = done_seen;
    repeat (40) tick();
    chk("t5_no_done", done_seen - d0, 0);
    rst_n = 1'b1;
    tick();
    run_meas(16'd100, 16'd400, lat);
    chk("t5_latency", lat, LAT);
    chk("t5_phase_after", phase_x10, 900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_meas_ctrl.md
Name: phase_meas_ctrl

Overview:
- Sequences the XOR-based phase-measurement datapath: on a start command it discards the first (possibly partial) measurement, then accumulates AVG_N consecutive high_times/all_times captures.
- Converts the averaged ratio to phase in 0.1-degree units using a multicycle restoring divider.
- Detects a missing or stalled input with a timeout.
- Sits between the phase-measurement block and the host/display logic.

Parameters:
- AVG_N, 8: periods averaged per measurement. Power of two, 2..256.
- TIMEOUT_CYC, 1000000: consecutive sys_clk cycles without phase_end_flag, while waiting, that abort the measurement.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle measurement request; sampled only in IDLE
- phase_end_flag  in  1  capture strobe from the measurement datapath
- high_times  in  16  XOR-high cycle count, valid with phase_end_flag
- all_times  in  16  period cycle count, valid with phase_end_flag
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle completion pulse (success or timeout)
- timeout_err  out  1  last measurement aborted by timeout; cleared on the next accepted start
- phase_x10  out  12  phase, 0..3600 (0.1-degree units)
- high_sum  out  SUM_W  accumulated high_times, SUM_W = 16 + log2(AVG_N)
- all_sum  out  SUM_W  accumulated all_times

Behaviour:
- Reset (asynchronous, active-low; clock sys_clk): state IDLE; busy, done and timeout_err are 0; phase_x10, high_sum and all_sum are 0; internal counters are 0.
- IDLE:
  - start=1: clear timeout_err, the accumulators, the counted-flag count and the timeout counter; go to SYNC.
  - phase_end_flag is ignored in IDLE, including in the same cycle as start.
- SYNC:
  - First phase_end_flag is discarded; go to ACCUM and clear the timeout counter.
- ACCUM:
  - Each phase_end_flag adds high_times/all_times to the accumulators (registered on that edge) and increments the count.
  - On the AVG_N-th counted flag, go to DIV.
  - high_sum/all_sum are updated live during accumulation.
- Timeout (SYNC/ACCUM only):
  - The counter increments every cycle without a flag and clears on a flag.
  - When the counter reaches TIMEOUT_CYC, go to DONE with timeout_err=1.
  - phase_x10 keeps its previous value; the sums keep their partial values.
  - A flag arriving in the same cycle as expiry wins: it is counted and no timeout occurs.
- DIV:
  - Dividend = high_sum*3600 (DW = SUM_W+12 bits), divisor = all_sum.
  - Restoring division, one quotient bit per cycle, MSB first; exactly DW cycles.
  - Quotient is truncated, then clamped to 3600.
  - all_sum==0 gives quotient 0.
  - phase_end_flag is ignored in DIV.
- DONE (one cycle):
  - done=1; phase_x10 was registered at the DIV→DONE transition on success.
  - Next state IDLE; busy drops on the same edge that done drops.
- Success latency: done is high in the cycle beginning DW+1 edges after the edge that samples the AVG_N-th counted flag.
- start while busy (SYNC/ACCUM/DIV/DONE) is ignored; no queuing.
- Reset mid-operation returns everything to reset values immediately; no done pulse.
- Accumulators cannot overflow: AVG_N*65535 fits in SUM_W.

Test Plan:
1. AVG_N=8, start; discard flag carrying 5/7; then 8 flags carrying high=100, all=400 -> high_sum=800, all_sum=3200, phase_x10=900, one done pulse DW+1=32 cycles after the 8th flag, timeout_err=0, busy low after done.
2. 8 counted flags with high=all=65535 -> high_sum=all_sum=524280, no overflow, phase_x10=3600. Then 8 flags with high=1, all=7 -> 28800/56 -> phase_x10=514 (truncated).
3. After test 1, start with no flags for TIMEOUT_CYC cycles -> done pulse, timeout_err=1, phase_x10 stays 900. Next start clears timeout_err. A flag in the exact expiry cycle is counted and no timeout is raised.
4. start pulses during ACCUM and DIV -> ignored, and sums/result are identical to test 1. start coincident with a flag in IDLE -> that flag is neither counted nor used as the discard.
5. Assert rst_n low during DIV -> busy=0, done never pulses, phase_x10=0, sums=0. Then a fresh start completes normally.
6. Back-to-back: start issued in the cycle after done -> accepted; second measurement with high=200, all=400 -> phase_x10=1800.
